// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters.
// Registered strobes; read data is timed by MEM_LAT and tagged with the requester.
module mem_port_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 5,
   parameter int DW      = 24,
   parameter int MEM_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic               rvalid,
   output logic [2:0]         rid,
   output logic [DW-1:0]      rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata
);

   localparam int IW = $clog2(NREQ);
   localparam int SW = IW + 1;

   typedef enum logic {IDLE, RD_WAIT} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [IW-1:0]   id_q, id_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            rvalid_q, rvalid_d;
   logic [2:0]      rid_q, rid_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

   logic [IW-1:0]   pick;
   logic            pick_vld;
   logic [SW-1:0]   sum;

   // Rotating priority: nearest asserted request at or after rr_q wins.
   always_comb begin
      pick     = rr_q;
      pick_vld = 1'b0;
      sum      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_q} + SW'(k);
         if (sum >= SW'(NREQ)) begin
            sum = sum - SW'(NREQ);
         end
         if (req[sum[IW-1:0]]) begin
            pick     = sum[IW-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   // Next-state and registered strobe computation.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      gnt_d       = '0;
      rvalid_d    = 1'b0;
      rid_d       = rid_q;
      rdata_d     = rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d       = NREQ'(1) << pick;
               mem_en_d    = 1'b1;
               mem_we_d    = req_we[pick];
               mem_addr_d  = req_addr[pick*AW +: AW];
               mem_wdata_d = req_wdata[pick*DW +: DW];
               id_d        = pick;
               rr_d        = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
               if (!req_we[pick]) begin
                  state_d = RD_WAIT;
                  cnt_d   = 3'(MEM_LAT);
               end
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               rvalid_d = 1'b1;
               rdata_d  = mem_rdata;
               rid_d    = 3'(id_q);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         rvalid_q    <= 1'b0;
         rid_q       <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         rid_q       <= rid_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign rid       = rid_q;
   assign rdata     = rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model and a latency-timed memory.
module tb_mem_port_arbiter;

   localparam int N   = 4;
   localparam int AW  = 5;
   localparam int DW  = 24;
   localparam int LAT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt;
   logic            rvalid;
   logic [2:0]      rid;
   logic [DW-1:0]   rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
      .rvalid(rvalid), .rid(rid), .rdata(rdata), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory array: data shows up LAT-1 cycles after the strobe cycle,
   // inverted garbage before that.
   logic [DW-1:0] mem [32];
   logic [3:0]    age = 4'd15;
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en) age <= 4'd1;
      else if (age != 4'd15) age <= age + 4'd1;
   end
   assign mem_rdata = (LAT == 1 || (!mem_en && int'(age) >= LAT - 1))
                      ? mem[mem_addr] : ~mem[mem_addr];

   // Transaction model state and expected outputs.
   int            m_rr, m_wait, m_id;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_mem [32];
   logic [N-1:0]  e_gnt;
   logic          e_en, e_we, e_rvalid;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rdata;
   logic [2:0]    e_rid;

   task automatic model_reset();
      m_rr = 0; m_wait = 0; m_id = 0; m_addr = '0;
      e_gnt = '0; e_en = 0; e_we = 0; e_rvalid = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_rid = '0;
   endtask

   task automatic model_step();
      int j;
      e_gnt = '0; e_en = 0; e_we = 0; e_rvalid = 0;
      if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            e_rvalid = 1;
            e_rid    = 3'(m_id);
            e_rdata  = m_mem[m_addr];
         end
      end else if (req != '0) begin
         j = -1;
         for (int k = 0; k < N; k++)
            if (j < 0 && req[(m_rr + k) % N]) j = (m_rr + k) % N;
         e_gnt   = N'(1) << j;
         e_en    = 1;
         e_we    = req_we[j];
         e_addr  = req_addr[j*AW +: AW];
         e_wdata = req_wdata[j*DW +: DW];
         if (e_we) m_mem[e_addr] = e_wdata;
         else begin
            m_wait = LAT; m_id = j; m_addr = e_addr;
         end
         m_rr = (j + 1) % N;
      end
   endtask

   function automatic logic [62:0] obs();
      return {gnt, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rid, rdata};
   endfunction

   function automatic logic [62:0] expv();
      return {e_gnt, e_en, e_we, e_addr, e_wdata, e_rvalid, e_rid, e_rdata};
   endfunction

   task automatic set_req(input int i, input bit r, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i] = r;
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic new_op(input int i);
      set_req(i, $urandom_range(0, 2) != 0, 1'($urandom), AW'($urandom),
              DW'($urandom));
   endtask

   // One clock: model at the edge, sample at the falling edge, then the
   // requesters react to what they saw (0 hold, 1 drop on gnt, 2 random).
   task automatic tick(input int mode);
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (mode == 1 && gnt[i]) req[i] = 1'b0;
         if (mode == 2 && (gnt[i] || !req[i])) new_op(i);
      end
   endtask

   task automatic test_reset();
      req = '1; req_we = '1;
      for (int c = 0; c < 3; c++) begin
         tick(0);
         checks++;
         if (obs() !== 63'd0) begin
            errors++;
            $display("FAIL reset_c%0d got=%h exp=0", c, obs());
         end
      end
      req = '0; req_we = '0;
      rst = 1'b0;
   endtask

   task automatic test_writes();
      logic [N-1:0]  eg [5];
      logic [AW-1:0] ea [5];
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      ea = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
      for (int i = 0; i < N; i++) set_req(i, 1, 1, AW'(i), DW'(i));
      for (int c = 0; c < 5; c++) begin
         tick(0);
         checks++;
         if ({gnt, mem_en, mem_we, mem_addr} !== {eg[c], 1'b1, 1'b1, ea[c]}) begin
            errors++;
            $display("FAIL writes_seq_c%0d got=%h exp=%h", c,
                     {gnt, mem_en, mem_we, mem_addr}, {eg[c], 1'b1, 1'b1, ea[c]});
         end
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL writes_model_c%0d got=%h exp=%h", c, obs(), expv());
         end
      end
      req = '0;
      tick(1);
      checks++;
      if (obs() !== expv() || mem_en !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL writes_idle got=%h exp=%h", obs(), expv());
      end
   endtask

   task automatic test_fill();
      bit ok;
      int i;
      for (int a = 0; a < 32; a++) begin
         i = a % N;
         set_req(i, 1, 1, AW'(a), (a == 5) ? 24'hABCDEF : DW'($urandom));
         ok = 0;
         for (int w = 0; w < 4 && !ok; w++) begin
            tick(1);
            checks++;
            if (obs() !== expv()) begin
               errors++;
               $display("FAIL fill_a%0d got=%h exp=%h", a, obs(), expv());
            end
            if (gnt[i]) ok = 1;
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL fill_grant_a%0d got=none exp=gnt[%0d]", a, i);
            req = '0;
         end
      end
   endtask

   task automatic test_read();
      int c_rv, c_g;
      logic [2:0]    g_rid;
      logic [DW-1:0] g_rdata;
      c_rv = -1; c_g = -1; g_rid = '0; g_rdata = '0;
      set_req(2, 1, 0, 5'd5, '0);
      tick(1);
      checks++;
      if (gnt !== 4'b0100 || mem_we !== 1'b0 || mem_addr !== 5'd5) begin
         errors++;
         $display("FAIL read_grant got=%b/%b/%0d exp=0100/0/5", gnt, mem_we, mem_addr);
      end
      set_req(1, 1, 1, 5'd9, 24'h5A5A5A);
      for (int c = 1; c <= 6; c++) begin
         tick(1);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL read_model_c%0d got=%h exp=%h", c, obs(), expv());
         end
         if (rvalid && c_rv < 0) begin
            c_rv = c; g_rid = rid; g_rdata = rdata;
         end
         if (gnt != '0 && c_g < 0) c_g = c;
      end
      checks++;
      if (c_rv != LAT || g_rid !== 3'd2 || g_rdata !== 24'hABCDEF) begin
         errors++;
         $display("FAIL read_return got=t+%0d rid=%0d data=%h exp=t+%0d rid=2 data=abcdef",
                  c_rv, g_rid, g_rdata, LAT);
      end
      checks++;
      if (c_g != LAT + 1) begin
         errors++;
         $display("FAIL read_gap got=t+%0d exp=t+%0d", c_g, LAT + 1);
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] eg [4];
      eg = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
      set_req(2, 1, 1, 5'd20, DW'($urandom));
      tick(1);
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL fair_setup got=%b exp=0100", gnt);
      end
      set_req(0, 1, 1, 5'd21, DW'($urandom));
      set_req(3, 1, 1, 5'd22, DW'($urandom));
      for (int c = 0; c < 4; c++) begin
         tick(0);
         checks++;
         if (gnt !== eg[c] || obs() !== expv()) begin
            errors++;
            $display("FAIL fair_c%0d got=%b exp=%b", c, gnt, eg[c]);
         end
      end
      req = '0;
      tick(1);
   endtask

   task automatic test_reset_mid_read();
      bit saw_rv;
      logic [N-1:0] first;
      saw_rv = 0; first = '0;
      set_req(1, 1, 0, 5'd3, '0);
      tick(1);
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL rmr_grant got=%b exp=0010", gnt);
      end
      tick(1);
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs() !== 63'd0) begin
         errors++;
         $display("FAIL rmr_async got=%h exp=0", obs());
      end
      set_req(1, 1, 1, 5'd10, DW'($urandom));
      set_req(2, 1, 1, 5'd11, DW'($urandom));
      tick(0);
      tick(0);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick(1);
         if (rvalid) saw_rv = 1;
         if (gnt != '0 && first == '0) first = gnt;
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL rmr_model_c%0d got=%h exp=%h", c, obs(), expv());
         end
      end
      checks++;
      if (saw_rv || first !== 4'b0010) begin
         errors++;
         $display("FAIL rmr_after got=rv%0d gnt%b exp=rv0 gnt0010", saw_rv, first);
      end
   endtask

   task automatic test_mixed();
      logic [N-1:0]  g1, g2;
      bit            seen;
      logic [2:0]    g_rid;
      logic [DW-1:0] g_rdata;
      g1 = '0; g2 = '0; seen = 0; g_rid = '1; g_rdata = '0;
      set_req(0, 1, 1, 5'd0, DW'($urandom));
      tick(1);
      set_req(1, 1, 1, 5'd7, 24'h123456);
      set_req(0, 1, 0, 5'd7, '0);
      for (int c = 0; c < 8; c++) begin
         tick(1);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL mixed_model_c%0d got=%h exp=%h", c, obs(), expv());
         end
         if (gnt != '0) begin
            if (g1 == '0) g1 = gnt;
            else if (g2 == '0) g2 = gnt;
         end
         if (rvalid && !seen) begin
            seen = 1; g_rid = rid; g_rdata = rdata;
         end
      end
      checks++;
      if (g1 !== 4'b0010 || g2 !== 4'b0001) begin
         errors++;
         $display("FAIL mixed_order got=%b,%b exp=0010,0001", g1, g2);
      end
      checks++;
      if (!seen || g_rid !== 3'd0 || g_rdata !== 24'h123456) begin
         errors++;
         $display("FAIL mixed_read got=v%0d rid=%0d data=%h exp=v1 rid=0 data=123456",
                  seen, g_rid, g_rdata);
      end
   endtask

   task automatic test_random();
      int reads;
      reads = 0;
      for (int i = 0; i < N; i++) new_op(i);
      for (int c = 0; c < 400; c++) begin
         tick(2);
         if (rvalid) reads++;
         checks++;
         if (obs() !== expv() || (mem_we && !mem_en)) begin
            errors++;
            $display("FAIL random_c%0d got=%h exp=%h", c, obs(), expv());
         end
      end
      req = '0;
      for (int c = 0; c < LAT + 2; c++) begin
         tick(1);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL drain_c%0d got=%h exp=%h", c, obs(), expv());
         end
      end
      checks++;
      if (reads == 0) begin
         errors++;
         $display("FAIL random_reads got=0 exp=>0");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      model_reset();
      test_reset();
      test_writes();
      test_fill();
      test_read();
      test_fairness();
      test_reset_mid_read();
      test_mixed();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
